alu_sm_seq: RTL

ALU_SM_SEQ -- requirements
Module: alu_sm_seq

---
 rtl/alu_sm_pkg.sv | 12 +
 rtl/alu_sm_addsub.sv | 18 +
 rtl/alu_sm_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_sm_pkg.sv
// alu_sm_pkg: op encodings and FSM state constants shared by the alu_sm blocks
package alu_sm_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t MUL  = 2'd1;
    localparam state_t DONE = 2'd2;
endpackage

// File: rtl/alu_sm_addsub.sv
// alu_sm_addsub: combinational sign-magnitude add; caller passes the effective sign of b
module alu_sm_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         sa,
    input  logic [W-1:0] b,
    input  logic         sb,
    output logic [W:0]   res,
    output logic         sres
);
    logic a_ge;
    assign a_ge = a >= b;
    always_comb begin
        res  = (sa == sb) ? {1'b0, a} + {1'b0, b} : a_ge ? {1'b0, a - b} : {1'b0, b - a};
        sres = |res & ((sa == sb || a_ge) ? sa : sb);
    end
endmodule

// File: rtl/alu_sm_seq.sv
// alu_sm_seq: sequential sign-magnitude add/sub/mul ALU; multiplier built only with ALU_SM_MUL_EN
module alu_sm_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic           sa,
    input  logic [W-1:0]   b,
    input  logic           sb,
    input  logic [1:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] res,
    output logic           sres,
    output logic           err
);
    import alu_sm_pkg::*;

    state_t         state;
    logic [2*W-1:0] res_q;
    logic           sres_q;
    logic           err_q;
    logic [W:0]     as_res;
    logic           as_sres;

    alu_sm_addsub #(.W(W)) u_addsub (
        .a   (a),
        .sa  (sa),
        .b   (b),
        .sb  (sb ^ (op == OP_SUB)),
        .res (as_res),
        .sres(as_sres)
    );

`ifdef ALU_SM_MUL_EN
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mcand;
    logic           sgn;
    logic [W:0]     psum;
    logic [2*W-1:0] acc_nx;
    // acc = {partial product, remaining multiplier bits}; one shift-add per cycle
    assign psum   = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? mcand : {W{1'b0}}};
    assign acc_nx = {psum, acc[W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            res_q  <= '0;
            sres_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ALU_SM_MUL_EN
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            sgn    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        res_q  <= {{(W-1){1'b0}}, as_res};
                        sres_q <= as_sres;
                        err_q  <= 1'b0;
                        state  <= DONE;
                    end
`ifdef ALU_SM_MUL_EN
                    else if (op == OP_MUL) begin
                        acc   <= {{W{1'b0}}, b};
                        mcand <= a;
                        sgn   <= sa ^ sb;
                        cnt   <= '0;
                        err_q <= 1'b0;
                        state <= MUL;
                    end
`endif
                    else begin
                        res_q  <= '0;
                        sres_q <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= DONE;
                    end
                end
`ifdef ALU_SM_MUL_EN
                MUL: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        res_q  <= acc_nx;
                        sres_q <= sgn & |acc_nx;
                        state  <= DONE;
                    end
                end
`endif
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign res       = res_q;
    assign sres      = sres_q;
    assign err       = err_q;
endmodule
